// File: rtl/seg_capture_if.sv
// seg_capture_if: scanned 7-segment display bus plus recovered read-back values.
interface seg_capture_if #(parameter int DIGITS = 4);
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic [4*DIGITS-1:0] hex;
  logic [DIGITS-1:0]   digit_valid;
  logic                err;
  logic [7:0]          err_cnt;
  logic                frame_done;
  modport master (output an, seg, input hex, digit_valid, err, err_cnt, frame_done);
  modport slave  (input an, seg, output hex, digit_valid, err, err_cnt, frame_done);
endinterface

// File: rtl/seg_capture.sv
// seg_capture: recovers hex digits from a multiplexed active-low 7-segment bus once each glyph is stable.
module seg_capture #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input logic clk,
  input logic rst,
  seg_capture_if.slave bus
);
  localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [DIGITS-1:0]   s_an, p_an, mask, bit_sel, digit_valid;
  logic [6:0]          s_seg, p_seg;
  logic [3:0]          cnt, cnt_nx, lows, val;
  logic [SW-1:0]       sel;
  logic [4*DIGITS-1:0] hex;
  logic [7:0]          err_cnt;
  logic                selable, commit, legal, blank, full, err, frame_done;
  always_comb begin
    lows = '0;
    sel = '0;
    val = '0;
    legal = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (!s_an[i]) begin
        lows = lows + 4'd1;
        sel = SW'(i);
      end
    for (int i = 0; i < 16; i++)
      if (s_seg == GLYPH[i]) begin
        val = 4'(i);
        legal = 1'b1;
      end
  end
  assign selable = lows == 4'd1;
  assign cnt_nx  = !selable ? 4'd0 :
                   (s_an != p_an || s_seg != p_seg) ? 4'd1 :
                   cnt == 4'(STABLE) ? cnt : cnt + 4'd1;
  // Only the transition into saturation commits, so a held glyph reports once.
  assign commit  = selable && cnt_nx == 4'(STABLE) && cnt != 4'(STABLE);
  assign blank   = s_seg == 7'h7f;
  assign bit_sel = DIGITS'(1) << sel;
  assign full    = (mask | bit_sel) == '1;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_an <= '1;
      p_an <= '1;
      s_seg <= 7'h7f;
      p_seg <= 7'h7f;
      cnt <= '0;
      mask <= '0;
      hex <= '0;
      digit_valid <= '0;
      err <= 1'b0;
      err_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      s_an <= bus.an;
      s_seg <= bus.seg;
      p_an <= s_an;
      p_seg <= s_seg;
      cnt <= cnt_nx;
      err <= commit && !legal && !blank;
      frame_done <= commit && full;
      if (commit) mask <= full ? '0 : mask | bit_sel;
      if (commit && legal) hex[{sel, 2'b00} +: 4] <= val;
      if (commit && (legal || blank)) digit_valid[sel] <= legal;
      if (commit && !legal && !blank && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
    end
  end
  assign bus.hex = hex;
  assign bus.digit_valid = digit_valid;
  assign bus.err = err;
  assign bus.err_cnt = err_cnt;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: randomized and directed checks of seg_capture against a run-length reference model.
module tb_seg_capture;
  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_capture_if #(.DIGITS(DIGITS)) bus ();
  seg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [15:0] m_hex;
  logic [3:0]  m_valid, m_mask;
  logic        m_err, m_fd;
  int          m_errs, run;
  logic [10:0] pend, prev;

  function automatic logic [29:0] dut_vec();
    return {bus.hex, bus.digit_valid, bus.err, bus.err_cnt, bus.frame_done};
  endfunction

  function automatic logic [29:0] model_vec();
    return {m_hex, m_valid, m_err, 8'(m_errs > 255 ? 255 : m_errs), m_fd};
  endfunction

  task automatic model_reset();
    m_hex = '0; m_valid = '0; m_mask = '0; m_err = 0; m_fd = 0;
    m_errs = 0; run = 0; prev = 11'h7ff; pend = 11'h7ff;
  endtask

  // A digit is read once a single-anode pattern has been seen exactly STABLE times in a row.
  task automatic model_sample(input logic [10:0] x);
    logic [3:0] a;
    logic [6:0] sg;
    int d, g;
    a = x[10:7];
    sg = x[6:0];
    d = 0;
    g = -1;
    m_err = 0;
    m_fd = 0;
    if ($countones(~a) != 1) run = 0;
    else if (x == prev) run++;
    else run = 1;
    prev = x;
    if (run == STABLE) begin
      for (int i = 0; i < DIGITS; i++) if (!a[i]) d = i;
      for (int i = 0; i < 16; i++) if (sg == glyph[i]) g = i;
      if (g >= 0) begin
        m_hex[4*d +: 4] = 4'(g);
        m_valid[d] = 1'b1;
      end else if (sg == 7'h7f) m_valid[d] = 1'b0;
      else begin
        m_err = 1;
        m_errs++;
      end
      m_mask[d] = 1'b1;
      if (m_mask == 4'hf) begin
        m_fd = 1;
        m_mask = '0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s);
    rst = r;
    bus.an = a;
    bus.seg = s;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else begin
      model_sample(pend);
      pend = {a, s};
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) step(1'b1, 4'($urandom), 7'($urandom));
    n_cmp++;
    if (dut_vec() !== 30'd0) begin
      n_bad++;
      $display("FAIL reset: got %h want 0", dut_vec());
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) step(1'b0, 4'b1110, 7'b0110000);
    n_cmp++;
    if (bus.digit_valid !== 4'b0000 || bus.hex !== 16'h0) begin
      n_bad++;
      $display("FAIL early_commit: valid %b hex %h want 0000/0000", bus.digit_valid, bus.hex);
    end
    step(1'b0, 4'b1110, 7'b0110000);
    n_cmp++;
    if (bus.hex[3:0] !== 4'h3 || bus.digit_valid !== 4'b0001) begin
      n_bad++;
      $display("FAIL basic_commit: hex %h valid %b want 3/0001", bus.hex[3:0], bus.digit_valid);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'b1110, 7'b0110000);
      n_cmp++;
      if (dut_vec() !== model_vec() || bus.err !== 1'b0) begin
        n_bad++;
        $display("FAIL hold: got %h want %h", dut_vec(), model_vec());
      end
    end
    for (int k = 0; k < 3; k++) step(1'b0, 4'b1101, 7'b0010010);
    for (int k = 0; k < 6; k++) step(1'b0, 4'b1111, 7'b0010010);
    n_cmp++;
    if (bus.hex[7:4] !== 4'h0 || bus.digit_valid[1] !== 1'b0 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL threshold: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_frame();
    logic [3:0] anv [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] val [4] = '{4'h1, 4'h2, 4'h3, 4'hA};
    int pulses = 0;
    int at = -1;
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 6; k++) begin
        step(1'b0, anv[d], glyph[val[d]]);
        if (bus.frame_done === 1'b1) begin
          pulses++;
          at = d * 6 + k;
        end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
          n_bad++;
          $display("FAIL frame_scan: got %h want %h", dut_vec(), model_vec());
        end
      end
    n_cmp++;
    if (bus.hex !== 16'hA321 || bus.digit_valid !== 4'hf || pulses != 1 || at != 22) begin
      n_bad++;
      $display("FAIL frame: hex %h valid %b pulses %0d at %0d want A321/1111/1/22",
               bus.hex, bus.digit_valid, pulses, at);
    end
  endtask

  task automatic test_err_blank();
    int errs = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'b1011, 7'b1111110);
      if (bus.err === 1'b1) errs++;
    end
    n_cmp++;
    if (errs != 1 || bus.err_cnt !== 8'd1 || bus.hex[11:8] !== 4'h3) begin
      n_bad++;
      $display("FAIL illegal: pulses %0d err_cnt %0d hex %h want 1/1/3", errs, bus.err_cnt, bus.hex[11:8]);
    end
    errs = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'b1101, 7'b1111111);
      if (bus.err === 1'b1) errs++;
    end
    n_cmp++;
    if (errs != 0 || bus.digit_valid !== 4'b1101 || bus.hex[7:4] !== 4'h2 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL blank: pulses %0d valid %b hex %h want 0/1101/2", errs, bus.digit_valid, bus.hex[7:4]);
    end
  endtask

  task automatic test_ghost();
    logic [29:0] snap;
    snap = dut_vec();
    for (int k = 0; k < 20; k++) begin
      step(1'b0, k < 10 ? 4'b1100 : 4'b1111, glyph[8]);
      n_cmp++;
      if (dut_vec() !== snap || (k > 0 && dut.cnt !== 4'd0)) begin
        n_bad++;
        $display("FAIL ghost: got %h cnt %0d want %h cnt 0", dut_vec(), dut.cnt, snap);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 4'b1110, glyph[7]);
    step(1'b0, 4'b1110, glyph[7]);
    step(1'b1, 4'b1110, glyph[7]);
    n_cmp++;
    if (dut_vec() !== 30'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got %h want 0", dut_vec());
    end
    for (int k = 0; k < 4; k++) step(1'b0, 4'b1110, glyph[7]);
    n_cmp++;
    if (bus.digit_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_rerun: valid %b want 0000 after 4 edges", bus.digit_valid);
    end
    step(1'b0, 4'b1110, glyph[7]);
    n_cmp++;
    if (bus.hex[3:0] !== 4'h7 || bus.digit_valid !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_commit: hex %h valid %b want 7/0001", bus.hex[3:0], bus.digit_valid);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      int dw = int'($urandom_range(5, 8));
      for (int k = 0; k < dw; k++) step(1'b0, 4'b1110, glyph[v]);
      n_cmp++;
      if (bus.hex[3:0] !== 4'(v) || bus.digit_valid[0] !== 1'b1 || dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL sweep %0d: hex %h got %h want %h", v, bus.hex[3:0], dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a;
      logic [6:0] s;
      int r = int'($urandom_range(0, 99));
      int dw = int'($urandom_range(1, 7));
      a = r < 80 ? ~(4'd1 << $urandom_range(0, 3)) : r < 90 ? 4'hf : 4'($urandom);
      r = int'($urandom_range(0, 99));
      s = r < 60 ? glyph[$urandom_range(0, 15)] : r < 75 ? 7'h7f : 7'($urandom);
      for (int k = 0; k < dw; k++) begin
        step(1'b0, a, s);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
          n_bad++;
          $display("FAIL random %0d: got %h want %h", n, dut_vec(), model_vec());
        end
      end
    end
  endtask

  task automatic test_err_sat();
    for (int n = 0; n < 260; n++)
      for (int k = 0; k < 5; k++) step(1'b0, 4'b1110, n[0] ? 7'b1111101 : 7'b1111110);
    n_cmp++;
    if (bus.err_cnt !== 8'hff || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL err_sat: err_cnt %0d got %h want 255 / %h", bus.err_cnt, dut_vec(), model_vec());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.an = '1;
    bus.seg = 7'h7f;
    model_reset();
    test_reset();
    test_basic();
    test_frame();
    test_err_blank();
    test_ghost();
    test_mid_reset();
    test_sweep();
    test_random();
    test_err_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
